// File: rtl/tape_uart_pkg.sv
// tape_uart_pkg: shared states, frame sizes and counter sizing for the tape UART transmitter.
package tape_uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
  localparam int FRAME_BITS_8N1 = 10;
  localparam int FRAME_BITS_8E1 = 11;
  function automatic int div_cnt_w(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction
endpackage

// File: rtl/tape_uart_tx_if.sv
// tape_uart_tx_if: valid/ready byte handshake into the tape UART transmitter.
interface tape_uart_tx_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  modport master (output tx_data, tx_valid, input tx_ready);
  modport slave  (input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/tape_baud_tick.sv
// tape_baud_tick: CLK_DIV divider with synchronous restart, one-cycle tick on the last clock of each bit.
module tape_baud_tick
  import tape_uart_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_restart,
  output logic o_tick
);
  localparam int W = div_cnt_w(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
  logic [W-1:0] r_cnt;
  assign o_tick = (r_cnt == LAST);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else if (i_restart || o_tick) r_cnt <= '0;
    else r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/tape_uart_tx.sv
// tape_uart_tx: 8N1 serial transmitter fed by a valid/ready byte handshake.
// Define TAPE_UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module tape_uart_tx
  import tape_uart_pkg::*;
#(
  parameter int CLK_DIV = 16,
  parameter int DATA_W  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  tape_uart_tx_if.slave   s_tx,
  output logic            tx_out,
  output logic            busy
);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
`ifdef TAPE_UART_TX_PARITY_EN
  localparam tx_state_e AFTER_DATA = PARITY;
`else
  localparam tx_state_e AFTER_DATA = STOP;
`endif
  tx_state_e         r_state, w_next;
  logic [DATA_W-1:0] r_shift;
  logic [BW-1:0]     r_bits;
  logic              w_tick, w_accept, w_restart;
`ifdef TAPE_UART_TX_PARITY_EN
  logic              r_par;
`endif
  assign s_tx.tx_ready = (r_state == IDLE) & ena & ~rst;
  assign w_accept      = s_tx.tx_valid & s_tx.tx_ready;
  assign w_restart     = (r_state == IDLE);
  assign busy          = (r_state != IDLE);
  // divider is held at zero while idle so START gets a full bit period
  tape_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk       (clk),
    .rst       (rst),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   w_next = w_accept ? START : IDLE;
      START:  w_next = w_tick ? DATA : START;
      DATA:   w_next = (w_tick && r_bits == LAST_BIT) ? AFTER_DATA : DATA;
`ifdef TAPE_UART_TX_PARITY_EN
      PARITY: w_next = w_tick ? STOP : PARITY;
`endif
      STOP:   w_next = w_tick ? IDLE : STOP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_bits  <= '0;
    end else if (w_accept) begin
      r_shift <= s_tx.tx_data;
      r_bits  <= '0;
    end else if (r_state == DATA && w_tick) begin
      r_shift <= r_shift >> 1;
      r_bits  <= r_bits + 1'b1;
    end
  end
`ifdef TAPE_UART_TX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_par <= 1'b0;
    else if (w_accept) r_par <= ^s_tx.tx_data;
  end
`endif
  // line is decoded from registered state, so async reset forces it high at once
  always_comb begin
    tx_out = (r_state == START) ? 1'b0 : (r_state == DATA) ? r_shift[0] : 1'b1;
`ifdef TAPE_UART_TX_PARITY_EN
    if (r_state == PARITY) tx_out = r_par;
`endif
  end
endmodule

// File: tb/tb_tape_uart_tx.sv
// tb_tape_uart_tx: scoreboard bench for tape_uart_tx at CLK_DIV=4.
module tb_tape_uart_tx;
  localparam int CLK_DIV = 4;
`ifdef TAPE_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk = 1'b0, rst = 1'b1, ena = 1'b1;
  logic tx_out, busy;
  int cyc = 0, errors = 0, checks = 0;
  logic [7:0] exp_q[$];

  tape_uart_tx_if #(.DATA_W(8)) bus ();
  tape_uart_tx #(.CLK_DIV(CLK_DIV), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .ena(ena), .s_tx(bus), .tx_out(tx_out), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = d;
    if (NB == 11) f[9] = ^d;
    return f;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output int t0, output bit to);
    to = 1'b1;
    t0 = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (tx_out === 1'b0) begin
        t0 = cyc;
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_idle(output int t1, output bit to);
    to = 1'b1;
    t1 = 0;
    for (int i = 0; i < 200; i++) begin
      if (busy === 1'b0) begin
        t1 = cyc;
        to = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic read_bits(output logic [10:0] b);
    b = '1;
    repeat (CLK_DIV / 2) tick();
    b[0] = tx_out;
    for (int i = 1; i < NB; i++) begin
      repeat (CLK_DIV) tick();
      b[i] = tx_out;
    end
  endtask

  task automatic pop_exp(output logic [7:0] e);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
  endtask

  task automatic test_reset;
    int c, t0, t1;
    bit to;
    logic [10:0] b;
    logic [7:0] e;
    rst = 1'b1;
    bus.tx_valid = 1'b1;
    bus.tx_data = 8'hC3;
    repeat (3) begin
      tick();
      checks++;
      if ({tx_out, bus.tx_ready, busy} !== 3'b100)
        begin errors++; $display("FAIL reset_state: tx_out/ready/busy=%b want 100", {tx_out, bus.tx_ready, busy}); end
    end
    rst = 1'b0;
    c = cyc;
    exp_q.push_back(8'hC3);
    #1;
    checks++;
    if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b want 1", bus.tx_ready); end
    wait_start(t0, to);
    bus.tx_valid = 1'b0;
    checks++;
    if (to || t0 != c + 1) begin errors++; $display("FAIL first_accept: start at +%0d (timeout=%0d) want +1", t0 - c, to); end
    if (!to) begin
      read_bits(b);
      pop_exp(e);
      checks++;
      if (b[8:1] !== e) begin errors++; $display("FAIL reset_frame_data: got %h want %h", b[8:1], e); end
      wait_idle(t1, to);
    end
  endtask

  task automatic test_single_frame;
    int c, t0, t1;
    bit to;
    logic [10:0] b;
    logic [7:0] e;
    c = cyc;
    bus.tx_valid = 1'b1;
    bus.tx_data = 8'h55;
    exp_q.push_back(8'h55);
    wait_start(t0, to);
    bus.tx_valid = 1'b0;
    checks++;
    if (to || t0 != c + 1) begin errors++; $display("FAIL start_latency: start at +%0d (timeout=%0d) want +1", t0 - c, to); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_at_start: got %b want 1", busy); end
    read_bits(b);
    pop_exp(e);
    checks++;
    if (b !== frame_of(e)) begin errors++; $display("FAIL frame_55_bits: got %b want %b", b, frame_of(e)); end
    wait_idle(t1, to);
    checks++;
    if (to || t1 - t0 != CLK_DIV * NB) begin errors++; $display("FAIL busy_length: got %0d want %0d", t1 - t0, CLK_DIV * NB); end
    checks++;
    if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL ready_after_frame: got %b want 1", bus.tx_ready); end
  endtask

  task automatic test_back_to_back;
    int ta, tb2, t1;
    bit to1, to2;
    logic [10:0] b1, b2;
    logic [7:0] e;
    bus.tx_valid = 1'b1;
    bus.tx_data = 8'hA5;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    wait_start(ta, to1);
    bus.tx_data = 8'h3C;
    read_bits(b1);
    wait_start(tb2, to2);
    bus.tx_valid = 1'b0;
    read_bits(b2);
    pop_exp(e);
    checks++;
    if (to1 || b1 !== frame_of(e)) begin errors++; $display("FAIL b2b_first: got %h want %h", b1[8:1], e); end
    pop_exp(e);
    checks++;
    if (to2 || b2 !== frame_of(e)) begin errors++; $display("FAIL b2b_second: got %h want %h", b2[8:1], e); end
    checks++;
    if (tb2 - ta != CLK_DIV * NB + 1) begin errors++; $display("FAIL b2b_gap: start spacing %0d want %0d", tb2 - ta, CLK_DIV * NB + 1); end
    wait_idle(t1, to1);
  endtask

  task automatic test_ena;
    int t0, t1;
    bit to;
    logic [10:0] b;
    logic [7:0] e;
    ena = 1'b0;
    bus.tx_valid = 1'b1;
    bus.tx_data = 8'h99;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({tx_out, bus.tx_ready, busy} !== 3'b100)
        begin errors++; $display("FAIL ena_low_idle: cycle %0d tx_out/ready/busy=%b want 100", i, {tx_out, bus.tx_ready, busy}); end
    end
    bus.tx_data = 8'h0F;
    exp_q.push_back(8'h0F);
    ena = 1'b1;
    wait_start(t0, to);
    ena = 1'b0;
    bus.tx_valid = 1'b0;
    read_bits(b);
    pop_exp(e);
    checks++;
    if (to || b !== frame_of(e)) begin errors++; $display("FAIL ena_drop_frame: got %b want %b", b, frame_of(e)); end
    wait_idle(t1, to);
    checks++;
    if (to || t1 - t0 != CLK_DIV * NB) begin errors++; $display("FAIL ena_drop_length: got %0d want %0d", t1 - t0, CLK_DIV * NB); end
    ena = 1'b1;
  endtask

  task automatic test_reset_mid_frame;
    int t0, t1;
    bit to;
    logic [10:0] b;
    logic [7:0] e;
    bus.tx_valid = 1'b1;
    bus.tx_data = 8'hFF;
    wait_start(t0, to);
    bus.tx_valid = 1'b0;
    repeat (CLK_DIV * 4 + CLK_DIV / 2) tick();
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({tx_out, busy, bus.tx_ready} !== 3'b100)
      begin errors++; $display("FAIL rst_mid_data: tx_out/busy/ready=%b want 100", {tx_out, busy, bus.tx_ready}); end
    tick();
    rst = 1'b0;
    bus.tx_valid = 1'b1;
    bus.tx_data = 8'h00;
    wait_start(t0, to);
    bus.tx_valid = 1'b0;
    tick();
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({tx_out, busy} !== 2'b10) begin errors++; $display("FAIL rst_mid_start: tx_out/busy=%b want 10", {tx_out, busy}); end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({tx_out, busy, bus.tx_ready} !== 3'b101)
      begin errors++; $display("FAIL idle_after_rst: tx_out/busy/ready=%b want 101", {tx_out, busy, bus.tx_ready}); end
    bus.tx_valid = 1'b1;
    bus.tx_data = 8'h81;
    exp_q.push_back(8'h81);
    wait_start(t0, to);
    bus.tx_valid = 1'b0;
    read_bits(b);
    pop_exp(e);
    checks++;
    if (to || b !== frame_of(e)) begin errors++; $display("FAIL after_rst_frame: got %b want %b", b, frame_of(e)); end
    wait_idle(t1, to);
  endtask

`ifdef TAPE_UART_TX_PARITY_EN
  task automatic test_parity;
    int t0, t1;
    bit to;
    logic [10:0] b;
    logic [7:0] e;
    bus.tx_valid = 1'b1;
    bus.tx_data = 8'h07;
    exp_q.push_back(8'h07);
    wait_start(t0, to);
    bus.tx_valid = 1'b0;
    read_bits(b);
    pop_exp(e);
    checks++;
    if (to || b[8:1] !== e || b[9] !== 1'b1) begin errors++; $display("FAIL parity_07: data %h par %b want %h par 1", b[8:1], b[9], e); end
    wait_idle(t1, to);
    checks++;
    if (to || t1 - t0 != 44) begin errors++; $display("FAIL parity_length: got %0d want 44", t1 - t0); end
    bus.tx_valid = 1'b1;
    bus.tx_data = 8'h03;
    exp_q.push_back(8'h03);
    wait_start(t0, to);
    bus.tx_valid = 1'b0;
    read_bits(b);
    pop_exp(e);
    checks++;
    if (to || b[8:1] !== e || b[9] !== 1'b0) begin errors++; $display("FAIL parity_03: data %h par %b want %h par 0", b[8:1], b[9], e); end
    wait_idle(t1, to);
  endtask
`endif

  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data = 8'h00;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_ena();
    test_reset_mid_frame();
`ifdef TAPE_UART_TX_PARITY_EN
    test_parity();
`endif
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d bytes left want 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tape_uart_tx.md
Name: tape_uart_tx

Overview:
- Byte-serial UART transmitter inside the tt_um_nubcore_default_tape user project.
- Accepts a byte over a valid/ready handshake and shifts it out as an 8N1 frame: start bit, 8 data bits LSB-first, 1 stop bit.
- Drives a single uo_out bit, which the cocotb bench samples as the design's serial response stream.
- It is the transmit end of the serial link the bench receives on.

Parameters:
- CLK_DIV, 16, clock cycles per serial bit; legal range 2..65535.
- DATA_W, 8, payload bits per frame; fixed at 8 for the tape build, kept parametric for reuse.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous active-high reset.
- ena  input  1  design-select enable; gates acceptance of new bytes only.
- tx_data  input  DATA_W  byte to send; sampled on the accept edge.
- tx_valid  input  1  source has a byte.
- tx_ready  output  1  block can accept a byte this cycle.
- tx_out  output  1  serial line; idle high.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (async, while rst=1):
  - tx_out=1, tx_ready=0, busy=0.
  - State=IDLE; bit counter, divider counter and shift register all cleared.
  - Reset mid-frame aborts the frame immediately: tx_out returns high within the same cycle rst asserts.
- Handshake:
  - tx_ready = (state==IDLE) & ena & ~rst, combinational from registered state.
  - A byte is accepted on a rising edge where tx_valid & tx_ready.
  - tx_data is latched into the shift register; tx_valid may drop the next cycle.
- State machine:
  - IDLE -> START on accept.
  - START -> DATA after CLK_DIV cycles.
  - DATA -> STOP after DATA_W bit periods (or DATA -> PARITY when the optional feature is compiled in).
  - PARITY -> STOP after one bit period.
  - STOP -> IDLE after CLK_DIV cycles.
- Line values: START drives 0; DATA drives shift[0], shifting right at each bit-period boundary; STOP drives 1.
- Latency: tx_out falls on the first edge after the accept edge.
- Bit period: exactly CLK_DIV clocks per bit.
- Frame length: (2+DATA_W)*CLK_DIV clocks, i.e. 10*CLK_DIV for 8N1.
- busy: high from the edge after accept through the final STOP cycle; low in IDLE.
- Back-to-back frames: with tx_valid held high, the next byte is accepted in the first IDLE cycle. The gap between frames is therefore exactly 1 idle-high cycle.
- ena: deasserting ena in IDLE blocks acceptance. Deasserting it mid-frame has no effect; the frame completes.
- Counters:
  - Divider counter width $clog2(CLK_DIV), counting 0..CLK_DIV-1 and wrapping to 0 at the bit boundary.
  - Bit counter width $clog2(DATA_W+1).
  - No other overflow is possible.
- tx_valid asserted during rst: ignored; no accept until the first edge after rst deasserts.

Optional Feature:
- Macro: TAPE_UART_TX_PARITY_EN.
- Defined: PARITY state inserted between DATA and STOP.
  - Drives even parity, the XOR of the latched byte.
  - Frame becomes 11*CLK_DIV clocks.
- Undefined: PARITY state and parity logic absent; 8N1 frame as above.

Decomposition:
- Package tape_uart_pkg holds:
  - State enum tx_state_e: IDLE, START, DATA, PARITY, STOP.
  - Localparams FRAME_BITS_8N1=10 and FRAME_BITS_8E1=11.
  - Function for the divider counter width.
- One sub-module, tape_baud_tick: CLK_DIV counter with synchronous restart input, emitting a 1-cycle bit_tick at each bit boundary.
- Shift register and FSM stay in tape_uart_tx.

Test Plan:
- Reset: rst=1 for 3 cycles with tx_valid=1 -> tx_out=1, tx_ready=0, busy=0 throughout; first accept only on the edge after rst falls.
- Single frame, CLK_DIV=4, tx_data=0x55:
  - tx_out low on the edge after accept.
  - Sampled mid-bit, the line reads 0,1,0,1,0,1,0,1,0,1.
  - busy high exactly 40 cycles, then tx_ready=1.
- Back-to-back, tx_valid held, bytes 0xA5 then 0x3C:
  - Decoded bytes are 0xA5 then 0x3C.
  - Exactly one idle-high cycle between the stop bit of the first frame and the start bit of the second.
- ena low:
  - With ena=0 in IDLE and tx_valid=1 for 20 cycles -> no start bit, tx_ready=0.
  - ena dropped mid-frame of 0x0F -> frame completes intact.
- Reset mid-frame: rst pulsed during data bit 3 of 0xFF -> tx_out=1 the same cycle; block IDLE afterwards; the next byte 0x81 transmits correctly.
- With TAPE_UART_TX_PARITY_EN: byte 0x07 -> parity bit 1; byte 0x03 -> parity bit 0; frame = 44 cycles at CLK_DIV=4.
